pong_game_flow: RTL and testbench

- Top-level game-flow sequencer for Pong. It sits directly downstream of the main and paused menu blocks and consumes their `selection` outputs.
- It conditions the raw confirm and pause buttons (synchronize, debounce, press-edge detect).
- It runs the screen state machine and keeps both players' scores.
- It drives the active-low `menu_reset` used by the menu blocks, plus run/restart controls for the ball and paddle logic.

---
 rtl/pong_game_flow.sv | 208 ++++++++++++++++++++
 tb/tb_pong_game_flow.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/pong_game_flow.sv
// Pong game-flow sequencer: button conditioning, screen FSM, score keeping.
// Drives menu reset plus ball/paddle run and restart controls.

module pong_button_cond #(
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int CNT_WIDTH       = 18
) (
    input  logic clock,
    input  logic reset,
    input  logic button,
    output logic press
);

    localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);

    logic                 sync_a;
    logic                 sync_b;
    logic                 level;
    logic                 level_q;
    logic [CNT_WIDTH-1:0] count;

    // Two-flop synchronizer for the asynchronous button input.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync_a <= 1'b1;
            sync_b <= 1'b1;
        end else begin
            sync_a <= button;
            sync_b <= sync_a;
        end
    end

    // Accept a new level only after it stays different for the full window.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            level <= 1'b1;
            count <= '0;
        end else if (sync_b != level) begin
            if (count == CNT_LAST) begin
                level <= sync_b;
                count <= '0;
            end else begin
                count <= count + 1'b1;
            end
        end else begin
            count <= '0;
        end
    end

    // Single-cycle pulse on the edge after the debounced level falls.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            level_q <= 1'b1;
            press   <= 1'b0;
        end else begin
            level_q <= level;
            press   <= level_q & ~level;
        end
    end

endmodule

module pong_game_flow #(
    parameter int WIN_SCORE       = 7,
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int CNT_WIDTH       = 18
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       button_select,
    input  logic       button_pause,
    input  logic [2:0] main_selection,
    input  logic [2:0] paused_selection,
    input  logic       point_left,
    input  logic       point_right,
    output logic [1:0] screen,
    output logic       menu_reset,
    output logic       game_run,
    output logic       game_restart,
    output logic [3:0] score_left,
    output logic [3:0] score_right,
    output logic       winner
);

    typedef enum logic [1:0] {
        MAIN      = 2'd0,
        PLAYING   = 2'd1,
        PAUSED    = 2'd2,
        GAME_OVER = 2'd3
    } state_t;

    localparam logic [3:0] WIN = 4'(WIN_SCORE);

    state_t     state;
    state_t     state_n;
    logic [3:0] left_n;
    logic [3:0] right_n;
    logic [3:0] left_sum;
    logic [3:0] right_sum;
    logic       winner_n;
    logic       restart_n;
    logic       menu_reset_n;
    logic       select_press;
    logic       pause_press;

    pong_button_cond #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .CNT_WIDTH      (CNT_WIDTH)
    ) u_select (
        .clock (clock),
        .reset (reset),
        .button(button_select),
        .press (select_press)
    );

    pong_button_cond #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .CNT_WIDTH      (CNT_WIDTH)
    ) u_pause (
        .clock (clock),
        .reset (reset),
        .button(button_pause),
        .press (pause_press)
    );

    assign screen    = state;
    assign left_sum  = score_left + 4'(point_left);
    assign right_sum = score_right + 4'(point_right);

    // Screen state register together with scores and control outputs.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state        <= MAIN;
            score_left   <= '0;
            score_right  <= '0;
            winner       <= 1'b0;
            game_run     <= 1'b0;
            game_restart <= 1'b0;
            menu_reset   <= 1'b0;
        end else begin
            state        <= state_n;
            score_left   <= left_n;
            score_right  <= right_n;
            winner       <= winner_n;
            game_run     <= (state_n == PLAYING);
            game_restart <= restart_n;
            menu_reset   <= menu_reset_n;
        end
    end

    // Next screen, score updates and one-cycle control pulses.
    always_comb begin
        state_n      = state;
        left_n       = score_left;
        right_n      = score_right;
        winner_n     = winner;
        restart_n    = 1'b0;
        menu_reset_n = 1'b1;
        unique case (state)
            MAIN: begin
                if (select_press && main_selection == 3'd0) begin
                    state_n   = PLAYING;
                    left_n    = '0;
                    right_n   = '0;
                    winner_n  = 1'b0;
                    restart_n = 1'b1;
                end
            end
            PLAYING: begin
                if (pause_press) begin
                    state_n      = PAUSED;
                    menu_reset_n = 1'b0;
                end else begin
                    left_n  = left_sum;
                    right_n = right_sum;
                    if (left_sum == WIN || right_sum == WIN) begin
                        state_n  = GAME_OVER;
                        winner_n = (left_sum != WIN);
                    end
                end
            end
            PAUSED: begin
                if (select_press) begin
                    if (paused_selection == 3'd0) begin
                        state_n = PLAYING;
                    end else if (paused_selection == 3'd1) begin
                        state_n   = PLAYING;
                        left_n    = '0;
                        right_n   = '0;
                        restart_n = 1'b1;
                    end else if (paused_selection == 3'd2) begin
                        state_n      = MAIN;
                        menu_reset_n = 1'b0;
                    end
                end else if (pause_press) begin
                    state_n = PLAYING;
                end
            end
            GAME_OVER: begin
                if (select_press) begin
                    state_n      = MAIN;
                    menu_reset_n = 1'b0;
                end
            end
        endcase
    end

endmodule

// File: tb/tb_pong_game_flow.sv
// Directed bench for pong_game_flow with short debounce and win score.
// Table of press/point steps plus hand sequences for reset and glitches.

module tb_pong_game_flow;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       button_select = 1'b1;
    logic       button_pause = 1'b1;
    logic [2:0] main_selection = 3'd0;
    logic [2:0] paused_selection = 3'd0;
    logic       point_left = 1'b0;
    logic       point_right = 1'b0;
    logic [1:0] screen;
    logic       menu_reset;
    logic       game_run;
    logic       game_restart;
    logic [3:0] score_left;
    logic [3:0] score_right;
    logic       winner;

    int pass_cnt = 0;
    int total_cnt = 0;
    int mr_low = 0;
    int rs_high = 0;

    pong_game_flow #(
        .WIN_SCORE      (3),
        .DEBOUNCE_CYCLES(4),
        .CNT_WIDTH      (18)
    ) dut (
        .clock           (clock),
        .reset           (reset),
        .button_select   (button_select),
        .button_pause    (button_pause),
        .main_selection  (main_selection),
        .paused_selection(paused_selection),
        .point_left      (point_left),
        .point_right     (point_right),
        .screen          (screen),
        .menu_reset      (menu_reset),
        .game_run        (game_run),
        .game_restart    (game_restart),
        .score_left      (score_left),
        .score_right     (score_right),
        .winner          (winner)
    );

    always #5 clock = ~clock;

    // Pulse counters sampled away from the active edge.
    always @(negedge clock) begin
        if (!reset) begin
            if (!menu_reset) mr_low++;
            if (game_restart) rs_high++;
        end
    end

    // op: 0 point pulse, 1 select press, 2 pause press, 3 both presses
    typedef struct {
        int       op;
        logic [2:0] ms;
        logic [2:0] ps;
        logic     pl;
        logic     pr;
        int       e_scr;
        int       e_l;
        int       e_r;
        int       e_w;
        int       e_rs;
        int       e_mr;
    } vec_t;

    vec_t vecs[$];

    task automatic check(string name, int act, int exp);
        total_cnt++;
        if (act == exp) pass_cnt++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    function automatic vec_t mk(int op, int ms, int ps, int pl, int pr,
                                int e_scr, int e_l, int e_r, int e_w,
                                int e_rs, int e_mr);
        vec_t v;
        v.op = op; v.ms = 3'(ms); v.ps = 3'(ps);
        v.pl = 1'(pl); v.pr = 1'(pr);
        v.e_scr = e_scr; v.e_l = e_l; v.e_r = e_r; v.e_w = e_w;
        v.e_rs = e_rs; v.e_mr = e_mr;
        return v;
    endfunction

    task automatic apply(vec_t v);
        mr_low = 0;
        rs_high = 0;
        main_selection = v.ms;
        paused_selection = v.ps;
        if (v.op == 0) begin
            point_left = v.pl;
            point_right = v.pr;
            @(negedge clock);
            point_left = 1'b0;
            point_right = 1'b0;
            repeat (3) @(negedge clock);
        end else begin
            button_select = !(v.op == 1 || v.op == 3);
            button_pause = !(v.op == 2 || v.op == 3);
            repeat (12) @(negedge clock);
            button_select = 1'b1;
            button_pause = 1'b1;
            repeat (12) @(negedge clock);
        end
    endtask

    initial begin
        vecs.push_back(mk(0, 0, 0, 1, 1, 1, 1, 1, 0, 0, 0));
        vecs.push_back(mk(1, 0, 0, 0, 0, 1, 1, 1, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 1, 1, 1, 2, 2, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 1, 1, 3, 3, 3, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 1, 0, 3, 3, 3, 0, 0, 0));
        vecs.push_back(mk(2, 0, 0, 0, 0, 3, 3, 3, 0, 0, 0));
        vecs.push_back(mk(1, 0, 0, 0, 0, 0, 3, 3, 0, 0, 1));
        vecs.push_back(mk(1, 3, 0, 0, 0, 0, 3, 3, 0, 0, 0));
        vecs.push_back(mk(2, 0, 0, 0, 0, 0, 3, 3, 0, 0, 0));
        vecs.push_back(mk(1, 0, 0, 0, 0, 1, 0, 0, 0, 1, 0));
        vecs.push_back(mk(0, 0, 0, 1, 0, 1, 1, 0, 0, 0, 0));
        vecs.push_back(mk(2, 0, 0, 0, 0, 2, 1, 0, 0, 0, 1));
        vecs.push_back(mk(0, 0, 0, 0, 1, 2, 1, 0, 0, 0, 0));
        vecs.push_back(mk(2, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0));
        vecs.push_back(mk(2, 0, 0, 0, 0, 2, 1, 0, 0, 0, 1));
        vecs.push_back(mk(1, 0, 1, 0, 0, 1, 0, 0, 0, 1, 0));
        vecs.push_back(mk(2, 0, 0, 0, 0, 2, 0, 0, 0, 0, 1));
        vecs.push_back(mk(3, 0, 5, 0, 0, 2, 0, 0, 0, 0, 0));
        vecs.push_back(mk(3, 0, 2, 0, 0, 0, 0, 0, 0, 0, 1));
        vecs.push_back(mk(1, 0, 0, 0, 0, 1, 0, 0, 0, 1, 0));
        vecs.push_back(mk(0, 0, 0, 0, 1, 1, 0, 1, 0, 0, 0));
        vecs.push_back(mk(2, 0, 0, 0, 0, 2, 0, 1, 0, 0, 1));
        vecs.push_back(mk(1, 0, 0, 0, 0, 1, 0, 1, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 1, 1, 0, 2, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 1, 3, 0, 3, 1, 0, 0));
        vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 3, 1, 0, 1));
        vecs.push_back(mk(1, 0, 0, 0, 0, 1, 0, 0, 0, 1, 0));
        vecs.push_back(mk(0, 0, 0, 1, 1, 1, 1, 1, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 1, 0, 1, 2, 1, 0, 0, 0));

        // Reset state
        repeat (3) @(negedge clock);
        check("rst_screen", screen, 0);
        check("rst_menu_reset", menu_reset, 0);
        check("rst_scores", {score_left, score_right}, 0);
        check("rst_restart", game_restart, 0);
        reset = 1'b0;
        #1;
        check("mr_before_edge", menu_reset, 0);
        @(negedge clock);
        check("mr_after_edge", menu_reset, 1);
        mr_low = 0;
        rs_high = 0;
        repeat (12) @(negedge clock);
        check("idle_screen", screen, 0);
        check("idle_mr", mr_low, 0);

        // Glitchy select: never stable long enough
        main_selection = 3'd0;
        for (int i = 0; i < 12; i++) begin
            button_select = (i % 3 == 2);
            @(negedge clock);
        end
        check("glitch_screen", screen, 0);
        check("glitch_restart", rs_high, 0);
        button_select = 1'b0;
        repeat (10) @(negedge clock);
        button_select = 1'b1;
        repeat (12) @(negedge clock);
        check("start_screen", screen, 1);
        check("start_run", game_run, 1);
        check("start_restart_cnt", rs_high, 1);
        check("start_mr_cnt", mr_low, 0);

        // Table of steps
        for (int i = 0; i < vecs.size(); i++) begin
            apply(vecs[i]);
            check($sformatf("v%0d_screen", i), screen, vecs[i].e_scr);
            check($sformatf("v%0d_run", i), game_run,
                  int'(vecs[i].e_scr == 1));
            check($sformatf("v%0d_left", i), score_left, vecs[i].e_l);
            check($sformatf("v%0d_right", i), score_right, vecs[i].e_r);
            check($sformatf("v%0d_winner", i), winner, vecs[i].e_w);
            check($sformatf("v%0d_restart", i), rs_high, vecs[i].e_rs);
            check($sformatf("v%0d_mr", i), mr_low, vecs[i].e_mr);
        end

        // Reset in the middle of a pause debounce, scores 2/1
        button_pause = 1'b0;
        repeat (4) @(negedge clock);
        reset = 1'b1;
        #1;
        check("mid_rst_screen", screen, 0);
        check("mid_rst_scores", {score_left, score_right}, 0);
        check("mid_rst_run", game_run, 0);
        check("mid_rst_mr", menu_reset, 0);
        @(negedge clock);
        button_pause = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        mr_low = 0;
        rs_high = 0;
        repeat (20) @(negedge clock);
        check("post_rst_screen", screen, 0);
        check("post_rst_mr", mr_low, 0);
        check("post_rst_restart", rs_high, 0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
